// File: rtl/rom_req_arbiter_if.sv
// Requester and ROM-side signals of the shared ROM read arbiter.
// The master modport is the environment side; the arbiter uses the slave modport.
interface rom_req_arbiter_if #(
  parameter int NumReq = 2,
  parameter int Width  = 32,
  parameter int Aw     = 11
);
  logic [NumReq-1:0]    req_i;
  logic [NumReq*Aw-1:0] addr_i;
  logic [NumReq-1:0]    gnt_o;
  logic [NumReq-1:0]    rvalid_o;
  logic [Width-1:0]     rdata_o;
  logic                 rom_cs_o;
  logic [Aw-1:0]        rom_addr_o;
  logic [Width-1:0]     rom_dout_i;
  logic                 rom_dvalid_i;
  logic                 err_o;

  modport master (
    output req_i, addr_i, rom_dout_i, rom_dvalid_i,
    input  gnt_o, rvalid_o, rdata_o, rom_cs_o, rom_addr_o, err_o
  );

  modport slave (
    input  req_i, addr_i, rom_dout_i, rom_dvalid_i,
    output gnt_o, rvalid_o, rdata_o, rom_cs_o, rom_addr_o, err_o
  );
endinterface

// File: rtl/rom_req_arbiter.sv
// Round-robin sharing of one single-port ROM (fixed 1-cycle latency) between
// NumReq requesters, with response routing and a sticky dvalid protocol check.
module rom_req_arbiter #(
  parameter int NumReq = 2,
  parameter int Width  = 32,
  parameter int Depth  = 2048,
  parameter int Aw     = $clog2(Depth)
) (
  input logic              clk_i,
  input logic              rst_i,
  rom_req_arbiter_if.slave bus
);
  localparam int Pw = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [Pw-1:0]     rr_ptr;
  logic [Pw-1:0]     resp_id;
  logic [Pw-1:0]     gnt_idx;
  logic [Pw-1:0]     nxt_ptr;
  logic              any_gnt;
  logic              outstanding;
  logic              err_q;
  logic [NumReq-1:0] gnt;
  logic [NumReq-1:0] rvalid;
  logic [Aw-1:0]     addr_arr [NumReq];

  for (genvar k = 0; k < NumReq; k++) begin : g_addr
    assign addr_arr[k] = bus.addr_i[k*Aw +: Aw];
  end

  // First requester at or after rr_ptr wins; reset masks the grant entirely.
  always_comb begin
    int cand;
    cand    = 0;
    gnt     = '0;
    gnt_idx = '0;
    nxt_ptr = rr_ptr;
    any_gnt = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cand = (int'(rr_ptr) + i) % NumReq;
      if (!any_gnt && bus.req_i[Pw'(cand)]) begin
        any_gnt = 1'b1;
        gnt_idx = Pw'(cand);
        nxt_ptr = Pw'((cand + 1) % NumReq);
      end
    end
    if (rst_i) any_gnt = 1'b0;
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    rvalid = '0;
    if (outstanding && !rst_i) rvalid[resp_id] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      resp_id     <= '0;
      outstanding <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      outstanding <= any_gnt;
      if (any_gnt) begin
        resp_id <= gnt_idx;
        rr_ptr  <= nxt_ptr;
      end
      // dvalid must track the outstanding read exactly, in both directions.
      if (bus.rom_dvalid_i != outstanding) err_q <= 1'b1;
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.rom_cs_o   = any_gnt;
  assign bus.rom_addr_o = any_gnt ? addr_arr[gnt_idx] : '0;
  assign bus.rvalid_o   = rvalid;
  assign bus.rdata_o    = bus.rom_dout_i;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_rom_req_arbiter.sv
// Directed bench for rom_req_arbiter with a ROM model, an arbitration model
// and a queue of expected read data.
module tb_rom_req_arbiter;
  localparam int NumReq = 2;
  localparam int Width  = 32;
  localparam int Depth  = 2048;
  localparam int Aw     = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_dv = 1'b0;
  logic kill_dv  = 1'b0;
  logic dvalid_q = 1'b0;

  int checks = 0;
  int errors = 0;
  int nresp0 = 0;

  int         mptr = 0;
  logic       mout = 1'b0;
  int         mid  = 0;
  logic       merr = 1'b0;
  logic [31:0] sb[$];

  rom_req_arbiter_if #(.NumReq(NumReq), .Width(Width), .Aw(Aw)) bus ();

  rom_req_arbiter #(.NumReq(NumReq), .Width(Width), .Depth(Depth), .Aw(Aw)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [Aw-1:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  always @(posedge clk) begin
    dvalid_q <= bus.rom_cs_o;
    if (bus.rom_cs_o) bus.rom_dout_i <= img(bus.rom_addr_o);
  end
  assign bus.rom_dvalid_i = (dvalid_q & ~kill_dv) | force_dv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [Aw-1:0] a0, input logic [Aw-1:0] a1);
    bus.req_i  = r;
    bus.addr_i = {a1, a0};
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic step();
    int k;
    int c;
    logic [1:0]    eg;
    logic [1:0]    erv;
    logic [Aw-1:0] ea;
    logic [31:0]   ed;
    logic          dv;
    @(negedge clk);
    k  = -1;
    eg = '0;
    ea = '0;
    if (!rst) begin
      for (int i = 0; i < NumReq; i++) begin
        c = (mptr + i) % NumReq;
        if (k < 0 && bus.req_i[c]) k = c;
      end
    end
    if (k >= 0) begin
      eg[k] = 1'b1;
      ea    = bus.addr_i[k*Aw +: Aw];
    end
    chk("gnt", 64'(bus.gnt_o), 64'(eg));
    chk("rom_cs", 64'(bus.rom_cs_o), 64'(k >= 0));
    chk("rom_addr", 64'(bus.rom_addr_o), 64'(ea));
    erv = (mout && !rst) ? (2'b01 << mid) : 2'b00;
    chk("rvalid", 64'(bus.rvalid_o), 64'(erv));
    if (mout) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        ed = sb.pop_front();
        if (!rst) chk("rdata", 64'(bus.rdata_o), 64'(ed));
      end
    end
    chk("err", 64'(bus.err_o), 64'(merr));
    if (bus.rvalid_o[0]) nresp0++;
    dv = bus.rom_dvalid_i;
    if (rst) begin
      mptr = 0;
      mout = 1'b0;
      merr = 1'b0;
    end else begin
      if (dv != mout) merr = 1'b1;
      mout = (k >= 0);
      if (k >= 0) begin
        mid  = k;
        mptr = (k + 1) % NumReq;
        sb.push_back(img(ea));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(2'b00, '0, '0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // single requester
    drive(2'b01, 11'h010, '0); step();
    drive(2'b00, '0, '0);      step();

    // contention from reset: expect 01,10,01,10
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 11'(32 + i), 11'(288 + i));
      step();
    end
    drive(2'b00, '0, '0); step();

    // fairness: req1 held, req0 pulsed in cycle 3 only
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive((i == 3) ? 2'b11 : 2'b10, 11'h055, 11'(64 + i));
      step();
    end
    drive(2'b00, '0, '0); step();

    // reset while a read is in flight; rr_ptr must restart at 0
    drive(2'b01, 11'h0AA, '0); step();
    rst = 1'b1; step();
    rst = 1'b0;
    drive(2'b11, 11'h0AB, 11'h1AB); step();
    drive(2'b00, '0, '0); step();

    // spurious dvalid sets err_o, held until reset
    step();
    force_dv = 1'b1; step();
    force_dv = 1'b0;
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    step();

    // missing dvalid: still returns data, sets err_o
    kill_dv = 1'b1;
    drive(2'b01, 11'h123, '0); step();
    drive(2'b00, '0, '0);      step();
    step(); step();
    kill_dv = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    step();

    // full-rate sweep over every address
    nresp0 = 0;
    for (int i = 0; i < Depth; i++) begin
      drive(2'b01, 11'(i), '0);
      step();
    end
    drive(2'b00, '0, '0); step();
    chk("sweep_count", 64'(nresp0), 64'(Depth));
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
